// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for the shared 256x16 memory.
// Each access takes three cycles: a grant in IDLE, the memory cycle in ACCESS, and a registered response in RESP.
module mem_access_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_r;
  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_nxt_s;
  logic                owner_if_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                if_win_s;
  logic                ls_win_s;

  // Winner selection: LS by default; IF when LS is idle or after STARVE_LIMIT back-to-back LS wins.
  always_comb begin
    if_win_s = 1'b0;
    ls_win_s = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
      if (if_req && (!ls_req || (streak_r == STREAK_MAX))) begin
        if_win_s = 1'b1;
      end else if (ls_req) begin
        ls_win_s = 1'b1;
      end else begin
        if_win_s = 1'b0;
        ls_win_s = 1'b0;
      end
    end else begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end
  end

  // Starvation streak: counts LS wins that overtook a waiting fetch.
  always_comb begin
    streak_nxt_s = streak_r;
    if (state_r == IDLE) begin
      if (if_win_s || !if_req) begin
        streak_nxt_s = '0;
      end else if (ls_win_s && (streak_r != STREAK_MAX)) begin
        streak_nxt_s = streak_r + STREAK_W'(1);
      end else begin
        streak_nxt_s = streak_r;
      end
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  assign if_gnt    = if_win_s;
  assign ls_gnt    = ls_win_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // Access sequencer: latch the winning request, drive the memory for one cycle, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      streak_r   <= '0;
      owner_if_r <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
    end else begin
      streak_r <= streak_nxt_s;
      case (state_r)
        IDLE: begin
          if (if_win_s) begin
            owner_if_r <= 1'b1;
            we_r       <= 1'b0;
            addr_r     <= if_addr;
            mem_rd     <= 1'b1;
            mem_wr     <= 1'b0;
            busy       <= 1'b1;
            state_r    <= ACCESS;
          end else if (ls_win_s) begin
            owner_if_r <= 1'b0;
            we_r       <= ls_we;
            addr_r     <= ls_addr;
            wdata_r    <= ls_wdata;
            mem_rd     <= ~ls_we;
            mem_wr     <= ls_we;
            busy       <= 1'b1;
            state_r    <= ACCESS;
          end else begin
            state_r    <= IDLE;
          end
        end
        ACCESS: begin
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          state_r <= RESP;
          // The read word goes straight into the owner's response register.
          if (owner_if_r) begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end else begin
            ls_rvalid <= 1'b1;
            ls_rdata  <= we_r ? {DATA_W{1'b0}} : mem_rdata;
          end
        end
        RESP: begin
          if_rvalid <= 1'b0;
          ls_rvalid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          if_rvalid <= 1'b0;
          ls_rvalid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
